// File: rtl/chardisp_pkg.sv
// Shared types and constants for the character display AXI4-Lite to VRAM bridge.
// The bus-facing FSM encodings live here so debug tooling decodes them from one place.
package chardisp_pkg;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ISSUE = 2'd1,
        W_RESP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAIT  = 2'd2,
        R_RESP  = 2'd3
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Encoding of the arbiter's last_grant bit.
    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/chardisp_axi_arb.sv
// Two-requester round-robin arbiter for the shared VRAM port.
// A lone requester is granted combinationally; ties go to whoever was not served last.
module chardisp_axi_arb
    import chardisp_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic wr_req,
    input  logic rd_req,
    output logic wr_gnt,
    output logic rd_gnt
);

    logic last_grant;

    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (wr_req && rd_req) begin
            if (last_grant == GRANT_RD) begin
                wr_gnt = 1'b1;
            end else begin
                rd_gnt = 1'b1;
            end
        end else begin
            wr_gnt = wr_req;
            rd_gnt = rd_req;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= GRANT_WR;
        end else if (wr_gnt) begin
            last_grant <= GRANT_WR;
        end else if (rd_gnt) begin
            last_grant <= GRANT_RD;
        end
    end

endmodule

// File: rtl/chardisp_axi_bridge.sv
// AXI4-Lite slave that turns CPU register accesses into single-cycle VRAM port-A strobes.
// One outstanding write and one outstanding read; RDEN and WREN are never high together.
module chardisp_axi_bridge
    import chardisp_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] S_AWADDR,
    input  logic              S_AWVALID,
    output logic              S_AWREADY,
    input  logic [31:0]       S_WDATA,
    input  logic [3:0]        S_WSTRB,
    input  logic              S_WVALID,
    output logic              S_WREADY,
    output logic [1:0]        S_BRESP,
    output logic              S_BVALID,
    input  logic              S_BREADY,
    input  logic [ADDR_W-1:0] S_ARADDR,
    input  logic              S_ARVALID,
    output logic              S_ARREADY,
    output logic [31:0]       S_RDATA,
    output logic [1:0]        S_RRESP,
    output logic              S_RVALID,
    input  logic              S_RREADY,
    output logic [ADDR_W-1:0] WRADDR,
    output logic [3:0]        BYTEEN,
    output logic              WREN,
    output logic [31:0]       WRDATA,
    output logic [ADDR_W-1:0] RDADDR,
    output logic              RDEN,
    input  logic [31:0]       RDDATA,
    output wr_state_t         DBG_WSTATE,
    output rd_state_t         DBG_RSTATE
);

    localparam logic [1:0] RD_LAT_CNT = RD_LATENCY[1:0];

    // Handshakes: a transfer happens in any cycle where VALID and READY are both high at
    // the clock edge; a VALID we drive stays high with a stable payload until that edge.
    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic              aw_held, w_held;
    logic [ADDR_W-1:0] wraddr_q;
    logic [3:0]        byteen_q;
    logic [31:0]       wrdata_q;
    logic [ADDR_W-1:0] rdaddr_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rd_cnt;

    logic aw_hs, w_hs, ar_hs;
    logic wr_req, rd_req, wr_gnt, rd_gnt;
    logic rd_capture;

    assign aw_hs      = S_AWVALID && S_AWREADY;
    assign w_hs       = S_WVALID && S_WREADY;
    assign ar_hs      = S_ARVALID && S_ARREADY;
    assign rd_capture = (r_state == R_WAIT) && (rd_cnt == RD_LAT_CNT);

    // Requests are masked in reset so no strobe escapes in the cycle reset is applied.
    assign wr_req = (w_state == W_ISSUE) && !RST;
    assign rd_req = (r_state == R_ISSUE) && !RST;

    chardisp_axi_arb u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .wr_req (wr_req),
        .rd_req (rd_req),
        .wr_gnt (wr_gnt),
        .rd_gnt (rd_gnt)
    );

    // ---------------- write FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_ISSUE;
            W_ISSUE: if (wr_gnt) w_next = W_RESP;
            W_RESP:  if (S_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        S_AWREADY = (w_state == W_IDLE) && !aw_held && !RST;
        S_WREADY  = (w_state == W_IDLE) && !w_held && !RST;
        WREN      = (w_state == W_ISSUE) && wr_gnt;
        S_BVALID  = (w_state == W_RESP);
        S_BRESP   = AXI_RESP_OKAY;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wraddr_q <= '0;
            byteen_q <= '0;
            wrdata_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                wraddr_q <= S_AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                byteen_q <= S_WSTRB;
                wrdata_q <= S_WDATA;
            end
            if (w_state == W_IDLE && w_next == W_ISSUE) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    assign WRADDR = wraddr_q;
    assign BYTEEN = byteen_q;
    assign WRDATA = wrdata_q;

    // ---------------- read FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_ISSUE;
            R_ISSUE: if (rd_gnt) r_next = R_WAIT;
            R_WAIT:  if (rd_capture) r_next = R_RESP;
            R_RESP:  if (S_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        S_ARREADY = (r_state == R_IDLE) && !RST;
        RDEN      = (r_state == R_ISSUE) && rd_gnt;
        S_RVALID  = (r_state == R_RESP);
        S_RRESP   = AXI_RESP_OKAY;
    end

    // rd_cnt counts cycles since the RDEN cycle so capture lands exactly RD_LATENCY later,
    // regardless of any write strobes issued in between.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdaddr_q <= '0;
            rdata_q  <= '0;
            rd_cnt   <= '0;
        end else begin
            if (ar_hs) begin
                rdaddr_q <= S_ARADDR;
            end
            if (rd_gnt) begin
                rd_cnt <= 2'd1;
            end else if (r_state == R_WAIT && !rd_capture) begin
                rd_cnt <= rd_cnt + 2'd1;
            end
            if (rd_capture) begin
                rdata_q <= RDDATA;
            end
        end
    end

    assign RDADDR  = rdaddr_q;
    assign S_RDATA = rdata_q;

    assign DBG_WSTATE = w_state;
    assign DBG_RSTATE = r_state;

endmodule

// File: tb/tb_chardisp_axi_bridge.sv
// Directed and randomised bench for chardisp_axi_bridge with a VRAM port model and a
// word-level scoreboard memory holding the byte-masked result of every AXI write.
module tb_chardisp_axi_bridge;
  import chardisp_pkg::*;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [ADDR_W-1:0] S_AWADDR = '0;
  logic              S_AWVALID = 1'b0;
  logic              S_AWREADY;
  logic [31:0]       S_WDATA = '0;
  logic [3:0]        S_WSTRB = '0;
  logic              S_WVALID = 1'b0;
  logic              S_WREADY;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY = 1'b0;
  logic [ADDR_W-1:0] S_ARADDR = '0;
  logic              S_ARVALID = 1'b0;
  logic              S_ARREADY;
  logic [31:0]       S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RVALID;
  logic              S_RREADY = 1'b0;
  logic [ADDR_W-1:0] WRADDR;
  logic [3:0]        BYTEEN;
  logic              WREN;
  logic [31:0]       WRDATA;
  logic [ADDR_W-1:0] RDADDR;
  logic              RDEN;
  logic [31:0]       RDDATA;
  wr_state_t         DBG_WSTATE;
  rd_state_t         DBG_RSTATE;

  chardisp_axi_bridge #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WRDATA(WRDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDDATA(RDDATA),
    .DBG_WSTATE(DBG_WSTATE), .DBG_RSTATE(DBG_RSTATE)
  );

  // ---------------- VRAM port-A model ----------------
  // Read data is only valid exactly RD_LAT cycles after RDEN; other cycles carry junk.
  logic [31:0] vram [0:16383];
  logic [3:1]  pv = '0;
  logic [31:0] pd [1:3];
  logic [31:0] junk = 32'hDEAD_BEEF;

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = '0;
    for (int i = 1; i <= 3; i++) pd[i] = '0;
  end

  always @(posedge CLK) begin
    if (WREN) begin
      for (int b = 0; b < 4; b++)
        if (BYTEEN[b]) vram[WRADDR[15:2]][8*b +: 8] <= WRDATA[8*b +: 8];
    end
    pv    <= {pv[2:1], RDEN};
    pd[1] <= vram[RDADDR[15:2]];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
    junk  <= $urandom;
  end

  assign RDDATA = pv[RD_LAT] ? pd[RD_LAT] : junk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [31:0] sb_mem [0:4095];
  logic [31:0] exp_q [$];

  initial for (int i = 0; i < 4096; i++) sb_mem[i] = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void sb_write(input logic [15:0] addr, input logic [31:0] data,
                                   input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) sb_mem[addr[13:2]][8*b +: 8] = data[8*b +: 8];
  endfunction

  // ---------------- protocol monitor ----------------
  logic        b_stall_q = 1'b0;
  logic        r_stall_q = 1'b0;
  logic [31:0] rdata_prev = '0;

  always @(negedge CLK) begin
    #2;
    check("rden_wren_exclusive", 32'(RDEN && WREN), 32'd0);
    if (b_stall_q) check("bvalid_hold", 32'(S_BVALID), 32'd1);
    if (r_stall_q) begin
      check("rvalid_hold", 32'(S_RVALID), 32'd1);
      check("rdata_hold", S_RDATA, rdata_prev);
    end
    b_stall_q  = S_BVALID && !S_BREADY && !RST;
    r_stall_q  = S_RVALID && !S_RREADY && !RST;
    rdata_prev = S_RDATA;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int aw_dly = $urandom_range(0, 3);
    int w_dly  = $urandom_range(0, 3);
    int n = 0;
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit b_done  = 1'b0;
    while (!(aw_done && w_done) && n < 40) begin
      cyc();
      S_AWVALID = !aw_done && (n >= aw_dly);
      S_AWADDR  = addr;
      S_WVALID  = !w_done && (n >= w_dly);
      S_WDATA   = data;
      S_WSTRB   = strb;
      S_BREADY  = 1'b0;
      S_RREADY  = 1'b0;
      settle();
      if (S_AWVALID && S_AWREADY) aw_done = 1'b1;
      if (S_WVALID && S_WREADY) w_done = 1'b1;
      n++;
    end
    check("aw_w_accept", 32'({aw_done, w_done}), 32'd3);
    sb_write(addr, data, strb);
    n = 0;
    while (!b_done && n < 40) begin
      cyc();
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b0;
      S_BREADY  = ($urandom_range(0, 2) != 0);
      settle();
      if (S_BVALID && S_BREADY) begin
        b_done = 1'b1;
        check("bresp", 32'(S_BRESP), 32'd0);
      end
      n++;
    end
    check("b_done", 32'(b_done), 32'd1);
  endtask

  task automatic axi_read(input logic [15:0] addr);
    int n = 0;
    bit ar_done = 1'b0;
    bit r_done  = 1'b0;
    logic [31:0] exp;
    exp_q.push_back(sb_mem[addr[13:2]]);
    while (!ar_done && n < 40) begin
      cyc();
      S_ARVALID = 1'b1;
      S_ARADDR  = addr;
      S_RREADY  = 1'b0;
      S_BREADY  = 1'b0;
      settle();
      if (S_ARREADY) ar_done = 1'b1;
      n++;
    end
    check("ar_accept", 32'(ar_done), 32'd1);
    n = 0;
    while (!r_done && n < 40) begin
      cyc();
      S_ARVALID = 1'b0;
      S_RREADY  = ($urandom_range(0, 2) != 0);
      settle();
      if (S_RVALID && S_RREADY) begin
        r_done = 1'b1;
        exp = exp_q.pop_front();
        check("rdata", S_RDATA, exp);
        check("rresp", 32'(S_RRESP), 32'd0);
      end
      n++;
    end
    check("r_done", 32'(r_done), 32'd1);
  endtask

  function automatic logic [15:0] pick_addr();
    logic [11:0] word;
    logic [1:0]  low;
    if ($urandom_range(0, 1) == 1) word = 12'($urandom_range(0, 31));
    else word = 12'($urandom_range(0, 4095));
    low = 2'($urandom_range(0, 3));
    return {2'b00, word, low};
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] addr;
    logic [31:0] data;

    // Reset state, sampled while RST is still high
    cyc(); cyc(); settle();
    check("rst_awready", 32'(S_AWREADY), 32'd0);
    check("rst_wready", 32'(S_WREADY), 32'd0);
    check("rst_arready", 32'(S_ARREADY), 32'd0);
    check("rst_bvalid", 32'(S_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_RVALID), 32'd0);
    check("rst_wren", 32'(WREN), 32'd0);
    check("rst_rden", 32'(RDEN), 32'd0);
    check("rst_wraddr", 32'(WRADDR), 32'd0);
    check("rst_byteen", 32'(BYTEEN), 32'd0);
    check("rst_wrdata", WRDATA, 32'd0);
    check("rst_rdaddr", 32'(RDADDR), 32'd0);
    check("rst_rdata", S_RDATA, 32'd0);
    check("rst_wstate", 32'(DBG_WSTATE), 32'(W_IDLE));
    check("rst_rstate", 32'(DBG_RSTATE), 32'(R_IDLE));
    cyc(); RST = 1'b0;
    cyc();

    // Single write, AW and W in the same cycle, B stalled for 3 cycles
    cyc();
    S_AWVALID = 1'b1; S_AWADDR = 16'h0010;
    S_WVALID = 1'b1; S_WDATA = 32'h00A5_F041; S_WSTRB = 4'b0111;
    settle();
    check("t1_awready", 32'(S_AWREADY), 32'd1);
    check("t1_wready", 32'(S_WREADY), 32'd1);
    sb_write(16'h0010, 32'h00A5_F041, 4'b0111);
    cyc(); S_AWVALID = 1'b0; S_WVALID = 1'b0; settle();
    check("t1_wren", 32'(WREN), 32'd1);
    check("t1_wraddr", 32'(WRADDR), 32'h0010);
    check("t1_byteen", 32'(BYTEEN), 32'b0111);
    check("t1_wrdata", WRDATA, 32'h00A5_F041);
    check("t1_bvalid_early", 32'(S_BVALID), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      check("t1_bvalid_stall", 32'(S_BVALID), 32'd1);
      check("t1_bresp", 32'(S_BRESP), 32'd0);
      check("t1_wren_once", 32'(WREN), 32'd0);
    end
    cyc(); S_BREADY = 1'b1; settle();
    check("t1_bvalid_hs", 32'(S_BVALID), 32'd1);
    cyc(); S_BREADY = 1'b0; settle();
    check("t1_bvalid_done", 32'(S_BVALID), 32'd0);

    // W at cycle 0, AW at cycle 4: WREN at cycle 5
    cyc();
    S_WVALID = 1'b1; S_WDATA = 32'h1234_5678; S_WSTRB = 4'hF;
    settle();
    check("t2_wready0", 32'(S_WREADY), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      S_WVALID = 1'b0;
      if (i == 4) begin S_AWVALID = 1'b1; S_AWADDR = 16'h0004; end
      settle();
      check("t2_wready_low", 32'(S_WREADY), 32'd0);
      check("t2_no_wren", 32'(WREN), 32'd0);
      if (i == 4) check("t2_awready", 32'(S_AWREADY), 32'd1);
    end
    sb_write(16'h0004, 32'h1234_5678, 4'hF);
    cyc(); S_AWVALID = 1'b0; settle();
    check("t2_wren", 32'(WREN), 32'd1);
    check("t2_wraddr", 32'(WRADDR), 32'h0004);
    check("t2_wrdata", WRDATA, 32'h1234_5678);
    cyc(); S_BREADY = 1'b1; settle();
    check("t2_bvalid", 32'(S_BVALID), 32'd1);
    cyc(); S_BREADY = 1'b0; settle();
    check("t2_bvalid_done", 32'(S_BVALID), 32'd0);

    // Read 0x0010: RDEN at n+1, RVALID at n+2+RD_LAT, held through 2 stall cycles
    cyc(); S_ARVALID = 1'b1; S_ARADDR = 16'h0010; settle();
    check("t3_arready", 32'(S_ARREADY), 32'd1);
    cyc(); S_ARVALID = 1'b0; settle();
    check("t3_rden", 32'(RDEN), 32'd1);
    check("t3_rdaddr", 32'(RDADDR), 32'h0010);
    for (int i = 2; i < 2 + RD_LAT; i++) begin
      cyc(); settle();
      check("t3_rvalid_early", 32'(S_RVALID), 32'd0);
      check("t3_rden_once", 32'(RDEN), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      check("t3_rvalid", 32'(S_RVALID), 32'd1);
      check("t3_rdata", S_RDATA, 32'h00A5_F041);
      check("t3_rresp", 32'(S_RRESP), 32'd0);
    end
    cyc(); S_RREADY = 1'b1; settle();
    check("t3_rvalid_hs", 32'(S_RVALID), 32'd1);
    cyc(); S_RREADY = 1'b0; settle();
    check("t3_rvalid_done", 32'(S_RVALID), 32'd0);

    // Contention from reset: read wins first, write next cycle
    cyc(); RST = 1'b1;
    cyc(); RST = 1'b0;
    cyc();
    S_AWVALID = 1'b1; S_AWADDR = 16'h0020;
    S_WVALID = 1'b1; S_WDATA = 32'hCAFE_0001; S_WSTRB = 4'hF;
    S_ARVALID = 1'b1; S_ARADDR = 16'h0010;
    settle();
    check("t4_all_ready", 32'({S_AWREADY, S_WREADY, S_ARREADY}), 32'd7);
    sb_write(16'h0020, 32'hCAFE_0001, 4'hF);
    cyc(); S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0; settle();
    check("t4_rden_first", 32'(RDEN), 32'd1);
    check("t4_wren_wait", 32'(WREN), 32'd0);
    cyc(); settle();
    check("t4_wren_second", 32'(WREN), 32'd1);
    check("t4_rden_off", 32'(RDEN), 32'd0);
    check("t4_wraddr", 32'(WRADDR), 32'h0020);
    cyc(); S_BREADY = 1'b1; settle();
    check("t4_bvalid", 32'(S_BVALID), 32'd1);
    cyc(); S_BREADY = 1'b0; S_RREADY = 1'b1; settle();
    check("t4_rvalid", 32'(S_RVALID), 32'd1);
    check("t4_rdata", S_RDATA, 32'h00A5_F041);
    cyc(); S_RREADY = 1'b0; settle();
    check("t4_rvalid_done", 32'(S_RVALID), 32'd0);

    // Reset while the read sits in R_WAIT
    cyc(); S_ARVALID = 1'b1; S_ARADDR = 16'h0004; settle();
    cyc(); S_ARVALID = 1'b0; settle();
    check("t5_rden", 32'(RDEN), 32'd1);
    cyc(); RST = 1'b1; settle();
    cyc(); RST = 1'b0; settle();
    check("t5_rvalid_rst", 32'(S_RVALID), 32'd0);
    check("t5_bvalid_rst", 32'(S_BVALID), 32'd0);
    check("t5_rden_rst", 32'(RDEN), 32'd0);
    check("t5_wren_rst", 32'(WREN), 32'd0);
    S_RREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      check("t5_no_stale_r", 32'(S_RVALID), 32'd0);
    end

    // Reset while the write sits in W_RESP
    cyc(); S_RREADY = 1'b0;
    S_AWVALID = 1'b1; S_AWADDR = 16'h0030;
    S_WVALID = 1'b1; S_WDATA = 32'h5555_AAAA; S_WSTRB = 4'hF;
    settle();
    sb_write(16'h0030, 32'h5555_AAAA, 4'hF);
    cyc(); S_AWVALID = 1'b0; S_WVALID = 1'b0; settle();
    cyc(); settle();
    check("t6_bvalid", 32'(S_BVALID), 32'd1);
    cyc(); RST = 1'b1; settle();
    cyc(); RST = 1'b0; settle();
    check("t6_bvalid_rst", 32'(S_BVALID), 32'd0);
    check("t6_rvalid_rst", 32'(S_RVALID), 32'd0);
    check("t6_wren_rst", 32'(WREN), 32'd0);
    check("t6_rden_rst", 32'(RDEN), 32'd0);
    check("t6_awready", 32'(S_AWREADY), 32'd1);
    S_BREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      check("t6_no_stale_b", 32'(S_BVALID), 32'd0);
    end
    axi_write(16'h0100, 32'h0BAD_F00D, 4'b1011);
    axi_read(16'h0100);
    axi_read(16'h0030);

    // Randomised traffic against the scoreboard memory
    for (int i = 0; i < 1000; i++) begin
      addr = pick_addr();
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        axi_write(addr, data, 4'($urandom_range(0, 15)));
      end else begin
        axi_read(addr);
      end
    end
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    cyc(); S_BREADY = 1'b0; S_RREADY = 1'b0;
    cyc(); cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/chardisp_axi_bridge.md
Name: chardisp_axi_bridge

Overview:
- AXI4-Lite slave that converts CPU register-space transactions into the single-cycle local VRAM bus used by the character display core: WRADDR/BYTEEN/WREN/WRDATA, RDADDR/RDEN/RDDATA.
- Sits directly upstream of the display core, between the AXI interconnect and the core's VRAM port A, all in the CLK domain.
- Guarantees RDEN and WREN are never high in the same cycle. This is required because the core muxes the VRAM address on RDEN.

Parameters:
- ADDR_W, 16, AXI and local address width in bits.
- RD_LATENCY, 2, cycles from the RDEN pulse to valid RDDATA; must match the VRAM port-A output register setting; legal range 1..3.

Ports:
- CLK  in  1  system/AXI clock
- RST  in  1  reset, synchronous, active-high
- S_AWADDR  in  ADDR_W  write address
- S_AWVALID  in  1 / S_AWREADY  out  1
- S_WDATA  in  32 / S_WSTRB  in  4 / S_WVALID  in  1 / S_WREADY  out  1
- S_BRESP  out  2 / S_BVALID  out  1 / S_BREADY  in  1
- S_ARADDR  in  ADDR_W / S_ARVALID  in  1 / S_ARREADY  out  1
- S_RDATA  out  32 / S_RRESP  out  2 / S_RVALID  out  1 / S_RREADY  in  1
- WRADDR  out  ADDR_W  local write byte address
- BYTEEN  out  4  local byte enables
- WREN  out  1  local write strobe, one cycle
- WRDATA  out  32  local write data
- RDADDR  out  ADDR_W  local read byte address
- RDEN  out  1  local read strobe, one cycle
- RDDATA  in  32  local read data, valid RD_LATENCY cycles after RDEN

Behaviour:
- Reset values:
  - All READY, VALID, WREN and RDEN outputs are 0.
  - Address, data, RESP and BYTEEN registers are 0.
  - Both FSMs return to IDLE and any in-flight transaction is discarded; no B or R response is issued for it.
- Write FSM, states W_IDLE, W_ISSUE, W_RESP:
  - In W_IDLE, S_AWREADY=1 until an AW handshake, and S_WREADY=1 until a W handshake. AW and W are accepted independently, in either order or in the same cycle, and latched.
  - When both are latched: go to W_ISSUE and wait for a grant.
  - On grant: WREN=1 for exactly one cycle, with WRADDR = latched AWADDR, BYTEEN = latched WSTRB, WRDATA = latched WDATA. Next state W_RESP.
  - In W_RESP, S_BVALID=1 and S_BRESP=2'b00. Hold until S_BREADY, then return to W_IDLE.
  - No new AW or W is accepted before the B handshake completes (one outstanding write).
- Read FSM, states R_IDLE, R_ISSUE, R_WAIT, R_RESP:
  - In R_IDLE, S_ARREADY=1. An AR handshake latches ARADDR; next state R_ISSUE.
  - On grant: RDEN=1 for one cycle with RDADDR = latched address; go to R_WAIT.
  - The R_WAIT counter captures RDDATA into the S_RDATA register exactly RD_LATENCY cycles after the RDEN cycle, then moves to R_RESP.
  - In R_RESP, S_RVALID=1 and S_RRESP=2'b00; S_RDATA is held stable until S_RREADY. Then return to R_IDLE.
- Arbiter:
  - Grants at most one of W_ISSUE/R_ISSUE per cycle.
  - Round-robin on a last_grant bit (reset = write, so a read wins the first tie).
  - A lone requester is granted in the same cycle it reaches ISSUE.
- Latency with no contention:
  - Write: AW+W handshake cycle n → WREN at n+1 → BVALID at n+2.
  - Read: AR handshake at n → RDEN at n+1 → RVALID at n+2+RD_LATENCY.
- Address handling:
  - Address bits [1:0] are passed through unmodified; the core ignores them.
  - No decode errors: every address returns OKAY.
- Simultaneous events: a write issued in cycles after a pending read's RDEN does not corrupt that read, because capture is cycle-exact.
- Stall behaviour: VALID outputs never drop without the matching READY; latched payloads never change while VALID is held.

Decomposition:
- Package chardisp_pkg:
  - Write FSM state enum and read FSM state enum.
  - Constant AXI_RESP_OKAY = 2'b00.
  - Optionally the VramEntry packed struct, so software-facing field positions are defined once.
- One natural sub-module: chardisp_axi_arb, the two-requester round-robin grant with last_grant register.
- FSMs stay in the top module.

Test Plan:
- Single write: AW=0x0010 and W=0x00A5F041 with WSTRB=4'b0111 in the same cycle.
  - Required: WREN one cycle later with WRADDR=0x0010, BYTEEN=4'b0111, WRDATA=0x00A5F041.
  - Then BVALID=1, BRESP=0; BVALID held over 3 cycles of BREADY=0.
- W before AW: W at cycle 0, AW at cycle 4 (addr 0x0004).
  - Required: WREN exactly at cycle 5.
  - S_WREADY=0 during cycles 1–4.
- Read: AR=0x0010, with the RDDATA model returning 0x00A5F041 RD_LATENCY=2 cycles after RDEN.
  - Required: RDEN at n+1, RVALID at n+4, RDATA=0x00A5F041 held through 2 stall cycles of RREADY=0.
- Contention: a write reaches W_ISSUE in the same cycle a read reaches R_ISSUE, from reset.
  - Required: RDEN first, then WREN next cycle; never both high in any cycle (assertion on the whole run).
- Reset mid-operation: RST asserted in R_WAIT and in W_RESP.
  - Required: next cycle, all VALID=0, RDEN=WREN=0.
  - No stale response after reset release.
  - A fresh write then completes normally.
- Randomised back-to-back traffic: 1000 random reads and writes against a 4096-word scoreboard memory.
  - Required: every read returns the last written byte-masked data; no AXI protocol-assertion failures.
